// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register plus instruction fetch over a req/ready port, committing the next PC on retire
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_ready_i,
    input  logic [31:0] im_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        exec_done_i,
    input  logic [1:0]  npc_op_i,
    input  logic        jump_i,
    input  logic        br_taken_i,
    input  logic [31:0] rs_data_i,
    output logic        fault_o
);
    localparam int CW = $clog2(FETCH_TIMEOUT + 1);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALT} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, instr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   plus4, br_target, next_pc;
    logic          fetch_hit, retire, misaligned, timed_out;

    assign plus4      = pc_q + 32'd4;
    assign br_target  = plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign fetch_hit  = state_q == S_FETCH && im_ready_i;
    assign retire     = state_q == S_EXEC && exec_done_i;
    assign misaligned = next_pc[1:0] != 2'b00;
    assign timed_out  = cnt_q == CW'(FETCH_TIMEOUT - 1);

    // next PC selection; reserved op 11 falls back to sequential
    always_comb begin
        next_pc = npc_op_i == 2'b01 ? (br_taken_i ? br_target : plus4) :
                  npc_op_i == 2'b10 ? (jump_i ? {plus4[31:28], instr_q[25:0], 2'b00} : rs_data_i) :
                  plus4;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    // next-state logic; a ready response wins over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: state_d = im_ready_i ? S_EXEC : (timed_out ? S_HALT : S_FETCH);
            S_EXEC:  state_d = exec_done_i ? (misaligned ? S_HALT : S_FETCH) : S_EXEC;
            default: state_d = S_HALT;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        im_req_o      = state_q == S_FETCH;
        instr_valid_o = state_q == S_EXEC;
        fault_o       = state_q == S_HALT;
    end

    // PC, fetched word and wait counter; a misaligned target leaves PC untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= retire && !misaligned ? next_pc : pc_q;
            instr_q <= fetch_hit ? im_rdata_i : instr_q;
            cnt_q   <= state_q == S_FETCH && !im_ready_i ? cnt_q + 1'b1 : '0;
        end
    end

    assign im_addr_o  = pc_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = plus4;
    assign instr_o    = instr_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized fetch/execute transactions against a PC-level reference model
module tb_pc_fetch_unit;
    logic        clk = 0, rst_n = 0;
    logic        im_req_o, instr_valid_o, fault_o;
    logic [31:0] im_addr_o, instr_o, pc_o, pc_plus4_o;
    logic        im_ready_i = 0, exec_done_i = 0, jump_i = 0, br_taken_i = 0;
    logic [31:0] im_rdata_i = 0, rs_data_i = 0;
    logic [1:0]  npc_op_i = 0;
    int          total = 0, bad = 0;
    logic [31:0] m_pc = 0, m_instr = 0;
    logic        halted;

    pc_fetch_unit #(.RESET_PC(32'h0), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .im_req_o(im_req_o), .im_addr_o(im_addr_o),
        .im_ready_i(im_ready_i), .im_rdata_i(im_rdata_i), .instr_o(instr_o),
        .instr_valid_o(instr_valid_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .exec_done_i(exec_done_i), .npc_op_i(npc_op_i), .jump_i(jump_i),
        .br_taken_i(br_taken_i), .rs_data_i(rs_data_i), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic [1:0] op, input logic j, input logic b,
                                               input logic [31:0] rs);
        logic [31:0] p4, off;
        p4  = pc + 32'd4;
        off = {{16{ins[15]}}, ins[15:0]};
        if (op == 2'd1 && b) return p4 + off * 32'd4;
        if (op == 2'd2) return j ? ((p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2)) : rs;
        return p4;
    endfunction

    task automatic do_reset();
        rst_n = 0; exec_done_i = 0; im_ready_i = 0;
        #1;
        check("rst_fault", fault_o, 0);
        check("rst_req", im_req_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_instr", instr_o, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        m_pc = 0; m_instr = 0;
    endtask

    task automatic fetch(input logic [31:0] w, input int dly);
        check("fetch_req", im_req_o, 1);
        check("fetch_addr", im_addr_o, m_pc);
        repeat (dly) begin
            exec_done_i = 1'($urandom); npc_op_i = 2'($urandom); rs_data_i = $urandom;
            @(negedge clk);
            exec_done_i = 0;
            check("wait_req", im_req_o, 1);
            check("wait_addr", im_addr_o, m_pc);
            check("wait_valid", instr_valid_o, 0);
        end
        im_ready_i = 1; im_rdata_i = w;
        @(negedge clk);
        im_ready_i = 0; im_rdata_i = $urandom;
        m_instr = w;
        check("got_valid", instr_valid_o, 1);
        check("got_instr", instr_o, m_instr);
        check("got_pc", pc_o, m_pc);
        check("got_pc4", pc_plus4_o, m_pc + 32'd4);
        check("got_req", im_req_o, 0);
    endtask

    task automatic exec(input logic [1:0] op, input logic j, input logic b, input logic [31:0] rs,
                        input int idle, output logic hlt);
        logic [31:0] nxt;
        repeat (idle) begin
            im_ready_i = 1; im_rdata_i = $urandom;
            @(negedge clk);
            im_ready_i = 0;
            check("idle_instr", instr_o, m_instr);
            check("idle_valid", instr_valid_o, 1);
            check("idle_pc", pc_o, m_pc);
        end
        exec_done_i = 1; npc_op_i = op; jump_i = j; br_taken_i = b; rs_data_i = rs;
        @(negedge clk);
        exec_done_i = 0;
        nxt = model_next(m_pc, m_instr, op, j, b, rs);
        hlt = nxt[1:0] != 2'b00;
        if (hlt) begin
            check("mis_fault", fault_o, 1);
            check("mis_req", im_req_o, 0);
            check("mis_valid", instr_valid_o, 0);
            check("mis_pc", pc_o, m_pc);
        end else begin
            m_pc = nxt;
            check("ret_fault", fault_o, 0);
            check("ret_req", im_req_o, 1);
            check("ret_addr", im_addr_o, nxt);
            check("ret_valid", instr_valid_o, 0);
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        fetch(32'h2408_0005, 0);
        exec(2'd0, 0, 0, 0, 0, halted);
        check("seq_addr4", im_addr_o, 32'h4);
        fetch(32'h0, 2);
        exec(2'd2, 0, 0, 32'h10, 1, halted);
        fetch(32'h1000_FFFC, 1);
        exec(2'd1, 0, 1, 0, 0, halted);
        check("br_taken_pc", pc_o, 32'h4);
        fetch(32'h0, 0);
        exec(2'd2, 0, 0, 32'h10, 0, halted);
        fetch(32'h1000_FFFC, 0);
        exec(2'd1, 0, 0, 0, 2, halted);
        check("br_not_pc", pc_o, 32'h14);
        fetch(32'h0, 0);
        exec(2'd2, 0, 0, 32'h3000_0008, 0, halted);
        fetch(32'h0C00_0040, 3);
        check("j_pc4", pc_plus4_o, 32'h3000_000C);
        exec(2'd2, 1, 0, 0, 0, halted);
        check("j_pc", pc_o, 32'h3000_0100);
        fetch(32'h0, 0);
        exec(2'd2, 0, 0, 32'hFFFF_FFFC, 0, halted);
        fetch(32'h0, 0);
        exec(2'd3, 0, 0, 0, 0, halted);
        check("wrap_pc", pc_o, 32'h0);
        fetch(32'h0, 0);
        exec(2'd2, 0, 0, 32'h200, 0, halted);
        check("jr_pc", pc_o, 32'h200);
        fetch(32'h0, 0);
        exec(2'd2, 0, 0, 32'h202, 0, halted);
        check("jr_mis_halt", halted, 1);
        repeat (3) @(negedge clk);
        check("halt_sticky", fault_o, 1);
        do_reset();
        for (int i = 0; i < 150; i++) begin
            logic [31:0] rs;
            rs = $urandom_range(0, 15) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
            fetch($urandom, $urandom_range(0, 12));
            exec(2'($urandom), 1'($urandom), 1'($urandom), rs, $urandom_range(0, 3), halted);
            if (halted) do_reset();
        end
        repeat (15) @(negedge clk);
        check("to_nofault", fault_o, 0);
        check("to_req", im_req_o, 1);
        @(negedge clk);
        check("to_fault", fault_o, 1);
        check("to_req_off", im_req_o, 0);
        do_reset();
        check("post_rst_req", im_req_o, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
